// File: rtl/borrow_skip_subtractor_pipe.sv
// Pipelined borrow-skip subtractor: diff = a - b - bin, one stage per BLOCK_SIZE-bit block.
// Latency: S = ceil(N/BLOCK_SIZE) cycles from input transfer to out_valid; 1 result/cycle.
// Backpressure: global stall when out_valid && !out_ready; in_ready = !out_valid || out_ready.
module borrow_skip_subtractor_pipe #(
    parameter int N          = 8,
    parameter int BLOCK_SIZE = 2,
    localparam int S         = (N + BLOCK_SIZE - 1) / BLOCK_SIZE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic [S-1:0] skip_mask
);

    typedef struct packed {
        logic         vld;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] d;
        logic         br;
        logic [S-1:0] skip;
    } stage_t;

    stage_t src  [S];
    stage_t nxt  [S];
    stage_t st_q [S];
    logic   advance;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = st_q[S-1].vld;
    assign diff      = st_q[S-1].d;
    assign bout      = st_q[S-1].br;
    assign skip_mask = st_q[S-1].skip;

    always_comb begin
        src[0]      = '0;
        src[0].vld  = in_valid;
        src[0].a    = a;
        src[0].b    = b;
        src[0].br   = bin;
        for (int k = 1; k < S; k++) begin
            src[k] = st_q[k-1];
        end
    end

    // Ripple chain per block; the skip mux picks the block borrow-in when every bit propagates.
    always_comb begin : blk_calc
        logic run;
        logic all_p;
        logic p;
        run   = 1'b0;
        all_p = 1'b1;
        p     = 1'b0;
        for (int k = 0; k < S; k++) begin
            nxt[k] = src[k];
            run    = src[k].br;
            all_p  = 1'b1;
            for (int i = k * BLOCK_SIZE; i < N && i < (k + 1) * BLOCK_SIZE; i++) begin
                p             = ~(src[k].a[i] ^ src[k].b[i]);
                nxt[k].d[i]   = src[k].a[i] ^ src[k].b[i] ^ run;
                run           = (~src[k].a[i] & src[k].b[i]) | (p & run);
                all_p         = all_p & p;
            end
            nxt[k].br      = all_p ? src[k].br : run;
            nxt[k].skip[k] = all_p;
        end
    end

    // Bubbles only clear the valid bit so the data of the last result stays put.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < S; k++) begin
                st_q[k] <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < S; k++) begin
                if (nxt[k].vld) begin
                    st_q[k] <= nxt[k];
                end else begin
                    st_q[k].vld <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_borrow_skip_subtractor_pipe.sv
// Bench for borrow_skip_subtractor_pipe: N=8/BS=2, N=1/BS=2 and N=7/BS=3 instances
// checked against an arithmetic reference model.
module tb_borrow_skip_subtractor_pipe;

    typedef struct packed {
        logic [7:0] d;
        logic       bo;
        logic [3:0] sk;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       v8, ir8, ov8, or8, bi8, bo8;
    logic [7:0] a8, b8, d8;
    logic [3:0] sk8;

    logic       v1, ir1, ov1, or1, a1, b1, bi1, d1, bo1;
    logic [0:0] sk1;

    logic       v7, ir7, ov7, or7, bi7, bo7;
    logic [6:0] a7, b7, d7;
    logic [2:0] sk7;

    int   errors = 0;
    int   checks = 0;
    res_t q8[$];
    res_t q7[$];

    borrow_skip_subtractor_pipe #(.N(8), .BLOCK_SIZE(2)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8), .a(a8), .b(b8), .bin(bi8),
        .out_valid(ov8), .out_ready(or8), .diff(d8), .bout(bo8), .skip_mask(sk8));

    borrow_skip_subtractor_pipe #(.N(1), .BLOCK_SIZE(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .a(a1), .b(b1), .bin(bi1),
        .out_valid(ov1), .out_ready(or1), .diff(d1), .bout(bo1), .skip_mask(sk1));

    borrow_skip_subtractor_pipe #(.N(7), .BLOCK_SIZE(3)) u_dut7 (
        .clk(clk), .rst(rst), .in_valid(v7), .in_ready(ir7), .a(a7), .b(b7), .bin(bi7),
        .out_valid(ov7), .out_ready(or7), .diff(d7), .bout(bo7), .skip_mask(sk7));

    // Reference: plain modular subtraction, unsigned compare, and "block slices equal" for skip.
    function automatic res_t model(input int n, input int bs, input logic [7:0] av,
                                   input logic [7:0] bv, input logic bi);
        res_t       r;
        logic [8:0] full;
        logic [7:0] m;
        logic [7:0] x;
        int         s, lo, w;
        m    = 8'((9'd1 << n) - 9'd1);
        av   = av & m;
        bv   = bv & m;
        full = {1'b0, av} - {1'b0, bv} - {8'd0, bi};
        r.d  = full[7:0] & m;
        r.bo = ({1'b0, av} < ({1'b0, bv} + {8'd0, bi}));
        r.sk = '0;
        s    = (n + bs - 1) / bs;
        x    = av ^ bv;
        for (int k = 0; k < s; k++) begin
            lo      = k * bs;
            w       = (n - lo < bs) ? n - lo : bs;
            r.sk[k] = ((x >> lo) & 8'((9'd1 << w) - 9'd1)) == 8'd0;
        end
        return r;
    endfunction

    // One clock of the 8-bit instance: drive at posedge+1, sample at negedge.
    task automatic cyc8(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                        input logic ordy, output logic acc, output logic ov, output logic ir,
                        output res_t got);
        v8 = v; a8 = av; b8 = bv; bi8 = bi; or8 = ordy;
        @(negedge clk);
        acc    = v8 && ir8;
        ov     = ov8;
        ir     = ir8;
        got.d  = d8;
        got.bo = bo8;
        got.sk = sk8;
        if (acc) q8.push_back(model(8, 2, av, bv, bi));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v8 = 0; a8 = 0; b8 = 0; bi8 = 0; or8 = 1;
        v1 = 0; a1 = 0; b1 = 0; bi1 = 0; or1 = 1;
        v7 = 0; a7 = 0; b7 = 0; bi7 = 0; or7 = 1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({ov8, d8, bo8, sk8} !== 14'd0) begin
            errors++;
            $display("FAIL reset_out8 got v=%b d=%h bo=%b sk=%b want all zero", ov8, d8, bo8, sk8);
        end
        checks++;
        if (ov1 !== 1'b0 || ov7 !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid_small got ov1=%b ov7=%b want 0 0", ov1, ov7);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got in_ready=%b out_valid=%b want 1 0", ir8, ov8);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [7:0] ta [3] = '{8'h05, 8'h00, 8'hA5};
        logic [7:0] tb [3] = '{8'h03, 8'h01, 8'hA5};
        logic       tbi[3] = '{1'b0, 1'b0, 1'b1};
        res_t       te [3] = '{'{8'h02, 1'b0, 4'b1100}, '{8'hFF, 1'b1, 4'b1110},
                               '{8'hFF, 1'b1, 4'b1111}};
        logic acc, ov, ir;
        res_t got;
        int   lat;
        for (int t = 0; t < 3; t++) begin
            cyc8(1'b1, ta[t], tb[t], tbi[t], 1'b1, acc, ov, ir, got);
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL directed_accept[%0d] got in_ready=%b want 1", t, ir);
            end
            lat = 0;
            for (int c = 1; c <= 12 && lat == 0; c++) begin
                cyc8(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, acc, ov, ir, got);
                if (ov) lat = c;
            end
            checks++;
            if (lat != 4) begin
                errors++;
                $display("FAIL directed_latency[%0d] got %0d want 4 (0 = timeout)", t, lat);
            end
            checks++;
            if (got !== te[t]) begin
                errors++;
                $display("FAIL directed_result[%0d] got d=%h bo=%b sk=%b want d=%h bo=%b sk=%b",
                         t, got.d, got.bo, got.sk, te[t].d, te[t].bo, te[t].sk);
            end
            cyc8(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, acc, ov, ir, got);
            checks++;
            if (ov !== 1'b0) begin
                errors++;
                $display("FAIL directed_dup[%0d] got out_valid=%b want 0", t, ov);
            end
            q8.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic acc, ov, ir;
        res_t got, exp;
        int   nout = 0;
        q8.delete();
        for (int c = 0; c < 20; c++) begin
            if (c < 6) cyc8(1'b1, 8'(c * 17), 8'(c), c[0], 1'b1, acc, ov, ir, got);
            else       cyc8(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, acc, ov, ir, got);
            if (c < 6) begin
                checks++;
                if (!acc) begin
                    errors++;
                    $display("FAIL b2b_accept[%0d] got in_ready=%b want 1", c, ir);
                end
            end
            if (ov) begin
                exp = (q8.size() > 0) ? q8.pop_front() : '1;
                checks++;
                if (got !== exp || c != nout + 4) begin
                    errors++;
                    $display("FAIL b2b_out[%0d] cycle=%0d d=%h bo=%b sk=%b want cycle=%0d d=%h bo=%b sk=%b",
                             nout, c, got.d, got.bo, got.sk, nout + 4, exp.d, exp.bo, exp.sk);
                end
                nout++;
            end
        end
        checks++;
        if (nout != 6) begin
            errors++;
            $display("FAIL b2b_count got %0d want 6", nout);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] va[5], vb[5];
        logic       vbi[5];
        logic       acc, ov, ir;
        res_t       got, exp, held;
        int         sent = 0, nout = 0, idx;
        q8.delete();
        held = '0;
        for (int i = 0; i < 5; i++) begin
            va[i] = 8'($urandom); vb[i] = 8'($urandom); vbi[i] = 1'($urandom);
        end
        for (int c = 0; c < 10; c++) begin
            idx = (sent < 5) ? sent : 0;
            cyc8(sent < 5, va[idx], vb[idx], vbi[idx], 1'b0, acc, ov, ir, got);
            if (acc) sent++;
            if (c == 4) begin
                checks++;
                if (ov !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_full got out_valid=%b want 1", ov);
                end
                held = got;
            end else if (c > 4) begin
                checks++;
                if (ov !== 1'b1 || ir !== 1'b0 || got !== held) begin
                    errors++;
                    $display("FAIL bp_stable[%0d] got v=%b rdy=%b d=%h bo=%b sk=%b want v=1 rdy=0 d=%h bo=%b sk=%b",
                             c, ov, ir, got.d, got.bo, got.sk, held.d, held.bo, held.sk);
                end
            end
        end
        checks++;
        if (sent != 4) begin
            errors++;
            $display("FAIL bp_accepted got %0d want 4", sent);
        end
        for (int c = 0; c < 30 && (sent < 5 || q8.size() > 0); c++) begin
            idx = (sent < 5) ? sent : 0;
            cyc8(sent < 5, va[idx], vb[idx], vbi[idx], 1'b1, acc, ov, ir, got);
            if (acc) sent++;
            if (ov) begin
                exp = (q8.size() > 0) ? q8.pop_front() : '1;
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL bp_drain[%0d] got d=%h bo=%b sk=%b want d=%h bo=%b sk=%b",
                             nout, got.d, got.bo, got.sk, exp.d, exp.bo, exp.sk);
                end
                nout++;
            end
        end
        cyc8(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, acc, ov, ir, got);
        checks++;
        if (nout != 5 || q8.size() != 0 || ov !== 1'b0) begin
            errors++;
            $display("FAIL bp_count got %0d outputs, %0d left, trailing v=%b want 5, 0, 0",
                     nout, q8.size(), ov);
        end
    endtask

    task automatic test_reset_midflight();
        logic acc, ov, ir;
        res_t got;
        logic stale = 1'b0;
        q8.delete();
        for (int c = 0; c < 3; c++)
            cyc8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, acc, ov, ir, got);
        rst = 1'b1;
        cyc8(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, acc, ov, ir, got);
        rst = 1'b0;
        cyc8(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, acc, ov, ir, got);
        checks++;
        if (ov !== 1'b0 || got.sk !== 4'd0 || ir !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state got v=%b sk=%b rdy=%b want 0 0000 1", ov, got.sk, ir);
        end
        for (int c = 0; c < 10; c++) begin
            cyc8(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, acc, ov, ir, got);
            if (ov !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale) begin
            errors++;
            $display("FAIL midreset_stale got out_valid=1 after reset want 0");
        end
        q8.delete();
    endtask

    task automatic test_n1();
        logic [2:0] bits;
        res_t       e;
        for (int i = 0; i < 8; i++) begin
            bits = 3'(i);
            v1 = 1'b1; a1 = bits[2]; b1 = bits[1]; bi1 = bits[0];
            e = model(1, 2, {7'd0, bits[2]}, {7'd0, bits[1]}, bits[0]);
            @(negedge clk);
            checks++;
            if (ov1 !== 1'b0 || ir1 !== 1'b1) begin
                errors++;
                $display("FAIL n1_idle[%0d] got v=%b rdy=%b want 0 1", i, ov1, ir1);
            end
            @(posedge clk);
            #1;
            v1 = 1'b0;
            @(negedge clk);
            checks++;
            if (ov1 !== 1'b1 || d1 !== e.d[0] || bo1 !== e.bo || sk1 !== e.sk[0:0]) begin
                errors++;
                $display("FAIL n1_result[%0d] got v=%b d=%b bo=%b sk=%b want v=1 d=%b bo=%b sk=%b",
                         i, ov1, d1, bo1, sk1, e.d[0], e.bo, e.sk[0]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_n7();
        res_t e;
        int   sent = 0, nout = 0;
        int   mode;
        logic need = 1'b1;
        q7.delete();
        for (int c = 0; c < 600 && nout < 40; c++) begin
            if (need) begin
                a7   = 7'($urandom);
                mode = int'($urandom_range(0, 2));
                if (mode == 0)      b7 = 7'($urandom);
                else if (mode == 1) b7 = a7;
                else                b7 = a7 ^ 7'(1 << $urandom_range(0, 6));
                bi7  = 1'($urandom);
                need = 1'b0;
            end
            v7  = (sent < 40) && ($urandom_range(0, 3) != 0);
            or7 = (sent >= 40) || ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (ov7 && or7) begin
                e = (q7.size() > 0) ? q7.pop_front() : '1;
                checks++;
                if ({d7, bo7, sk7} !== {e.d[6:0], e.bo, e.sk[2:0]}) begin
                    errors++;
                    $display("FAIL n7_out[%0d] got d=%h bo=%b sk=%b want d=%h bo=%b sk=%b",
                             nout, d7, bo7, sk7, e.d[6:0], e.bo, e.sk[2:0]);
                end
                nout++;
            end
            if (v7 && ir7) begin
                q7.push_back(model(7, 3, {1'b0, a7}, {1'b0, b7}, bi7));
                sent++;
                need = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        v7 = 1'b0;
        checks++;
        if (nout != 40 || q7.size() != 0) begin
            errors++;
            $display("FAIL n7_count got %0d outputs, %0d pending want 40, 0", nout, q7.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_n1();
        test_n7();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
